// File: rtl/odd_count_checker_if.sv
// rtl/odd_count_checker_if.sv - sample stream, control and status bundle for odd_count_checker
`timescale 1ns/1ps

interface odd_count_checker_if #(
   parameter int STAT_W = 8
);
   logic [3:0]        count_in;
   logic              valid_in;
   logic              restart;
   logic              clear_stats;
   logic              locked;
   logic [3:0]        expected;
   logic              err_pulse;
   logic [1:0]        err_code;
   logic [STAT_W-1:0] err_count;
   logic [STAT_W-1:0] wrap_count;

   modport master (
      output count_in, valid_in, restart, clear_stats,
      input  locked, expected, err_pulse, err_code, err_count, wrap_count
   );

   modport slave (
      input  count_in, valid_in, restart, clear_stats,
      output locked, expected, err_pulse, err_code, err_count, wrap_count
   );
endinterface

// File: rtl/odd_count_checker.sv
// rtl/odd_count_checker.sv - locks onto the odd counter stream and checks 1,3,...,15,1 sequencing
`timescale 1ns/1ps

module odd_count_checker #(
   parameter int GAP_MAX = 8,
   parameter int STAT_W  = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   odd_count_checker_if.slave      bus
);
   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   localparam logic [7:0]        gap_last = 8'(GAP_MAX - 1);
   localparam logic [STAT_W-1:0] stat_max = {STAT_W{1'b1}};

   state_t            state;
   logic [7:0]        gap_cnt;
   logic [3:0]        expected;
   logic              locked;
   logic              err_pulse;
   logic [1:0]        err_code;
   logic [STAT_W-1:0] err_count;
   logic [STAT_W-1:0] wrap_count;
   logic              err_inc;
   logic              wrap_inc;
   logic              match;

   assign match = (bus.count_in == expected);

   // Statistic events; a restart discards whatever sample arrives with it.
   always_comb begin
      err_inc  = 1'b0;
      wrap_inc = 1'b0;
      if (!bus.restart && state == LOCKED) begin
         if (bus.valid_in) begin
            if (match)
               wrap_inc = (bus.count_in == 4'd15);
            else
               err_inc = 1'b1;
         end else if (gap_cnt == gap_last) begin
            err_inc = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= HUNT;
         gap_cnt   <= 8'd0;
         expected  <= 4'd0;
         locked    <= 1'b0;
         err_pulse <= 1'b0;
         err_code  <= 2'b00;
      end else begin
         err_pulse <= 1'b0;
         if (bus.restart) begin
            state    <= HUNT;
            gap_cnt  <= 8'd0;
            expected <= 4'd0;
            locked   <= 1'b0;
            err_code <= 2'b00;
         end else begin
            case (state)
               HUNT: begin
                  if (bus.valid_in && bus.count_in[0]) begin
                     state    <= LOCKED;
                     locked   <= 1'b1;
                     expected <= bus.count_in + 4'd2;
                     gap_cnt  <= 8'd0;
                  end
               end
               LOCKED: begin
                  if (bus.valid_in) begin
                     gap_cnt <= 8'd0;
                     if (match) begin
                        expected <= expected + 4'd2;
                     end else begin
                        err_code  <= bus.count_in[0] ? 2'b01 : 2'b10;
                        err_pulse <= 1'b1;
                        expected  <= 4'd0;
                        locked    <= 1'b0;
                        state     <= HUNT;
                     end
                  end else if (gap_cnt == gap_last) begin
                     err_code  <= 2'b11;
                     err_pulse <= 1'b1;
                     expected  <= 4'd0;
                     locked    <= 1'b0;
                     gap_cnt   <= 8'd0;
                     state     <= HUNT;
                  end else begin
                     gap_cnt <= gap_cnt + 8'd1;
                  end
               end
               default: state <= HUNT;
            endcase
         end
      end
   end

   // clear_stats wins over a same-edge increment.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_count  <= '0;
         wrap_count <= '0;
      end else if (bus.clear_stats) begin
         err_count  <= '0;
         wrap_count <= '0;
      end else begin
         if (err_inc && err_count != stat_max)
            err_count <= err_count + 1'b1;
         if (wrap_inc && wrap_count != stat_max)
            wrap_count <= wrap_count + 1'b1;
      end
   end

   assign bus.locked     = locked;
   assign bus.expected   = expected;
   assign bus.err_pulse  = err_pulse;
   assign bus.err_code   = err_code;
   assign bus.err_count  = err_count;
   assign bus.wrap_count = wrap_count;
endmodule

// File: tb/tb_odd_count_checker.sv
// tb/tb_odd_count_checker.sv - directed bench for odd_count_checker
`timescale 1ns/1ps

module tb_odd_count_checker;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] count_in = 4'd0;
   logic       valid_in = 1'b0;
   logic       restart = 1'b0;
   logic       clear_stats = 1'b0;
   logic       pulse_seen;
   int         checks = 0;
   int         failures = 0;

   always #5 clk = ~clk;

   odd_count_checker_if #(.STAT_W(8)) bus ();
   odd_count_checker_if #(.STAT_W(2)) bus_s ();

   assign bus.count_in      = count_in;
   assign bus.valid_in      = valid_in;
   assign bus.restart       = restart;
   assign bus.clear_stats   = clear_stats;
   assign bus_s.count_in    = count_in;
   assign bus_s.valid_in    = valid_in;
   assign bus_s.restart     = restart;
   assign bus_s.clear_stats = clear_stats;

   odd_count_checker #(.GAP_MAX(8), .STAT_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   odd_count_checker #(.GAP_MAX(8), .STAT_W(2)) dut_sat (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_s)
   );

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Apply one cycle of stimulus, then sample 1 ns after the edge.
   task automatic step(input logic v, input logic [3:0] c);
      valid_in = v;
      count_in = c;
      @(posedge clk);
      #1;
      pulse_seen  = pulse_seen | bus.err_pulse;
      valid_in    = 1'b0;
      restart     = 1'b0;
      clear_stats = 1'b0;
   endtask

   initial begin
      pulse_seen = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_locked",   bus.locked, 0);
      check("rst_expected", bus.expected, 0);
      check("rst_pulse",    bus.err_pulse, 0);
      check("rst_code",     bus.err_code, 0);
      check("rst_errcnt",   bus.err_count, 0);
      check("rst_wrapcnt",  bus.wrap_count, 0);

      reset = 1'b1;
      step(1'b1, 4'd1);
      check("lock_first", bus.locked, 1);
      check("lock_exp3",  bus.expected, 3);
      step(1'b1, 4'd3);
      step(1'b1, 4'd5);
      check("lock_exp7",   bus.expected, 7);
      check("lock_errcnt", bus.err_count, 0);

      for (int v = 7; v <= 15; v += 2) step(1'b1, 4'(v));
      check("wrap_exp1", bus.expected, 1);
      step(1'b1, 4'd1);
      step(1'b1, 4'd3);
      check("wrap_cnt",    bus.wrap_count, 1);
      check("wrap_exp5",   bus.expected, 5);
      check("wrap_nopulse", pulse_seen, 0);

      step(1'b1, 4'd9);
      check("mm_pulse",  bus.err_pulse, 1);
      check("mm_code",   bus.err_code, 1);
      check("mm_errcnt", bus.err_count, 1);
      check("mm_locked", bus.locked, 0);
      check("mm_exp0",   bus.expected, 0);
      step(1'b0, 4'd0);
      check("mm_pulse_one", bus.err_pulse, 0);
      check("mm_code_held", bus.err_code, 1);

      step(1'b1, 4'd3);
      check("relock_exp5", bus.expected, 5);
      step(1'b1, 4'd6);
      check("even_code",   bus.err_code, 2);
      check("even_errcnt", bus.err_count, 2);
      check("even_pulse",  bus.err_pulse, 1);

      step(1'b1, 4'd1);
      check("b2b_locked", bus.locked, 1);
      check("b2b_pulse",  bus.err_pulse, 0);
      check("b2b_errcnt", bus.err_count, 2);

      pulse_seen = 1'b0;
      repeat (7) step(1'b0, 4'd0);
      check("to7_locked",  bus.locked, 1);
      check("to7_nopulse", pulse_seen, 0);
      step(1'b0, 4'd0);
      check("to8_code",   bus.err_code, 3);
      check("to8_pulse",  bus.err_pulse, 1);
      check("to8_locked", bus.locked, 0);
      check("to8_errcnt", bus.err_count, 3);

      step(1'b1, 4'd1);
      pulse_seen = 1'b0;
      repeat (7) step(1'b0, 4'd0);
      step(1'b1, 4'd3);
      check("gap7_nopulse", pulse_seen, 0);
      check("gap7_exp5",    bus.expected, 5);
      check("gap7_locked",  bus.locked, 1);
      check("gap7_errcnt",  bus.err_count, 3);

      restart = 1'b1;
      step(1'b1, 4'd4);
      check("rs_locked", bus.locked, 0);
      check("rs_pulse",  bus.err_pulse, 0);
      check("rs_code",   bus.err_code, 0);
      check("rs_exp",    bus.expected, 0);
      restart = 1'b1;
      step(1'b1, 4'd5);
      check("rs_odd_nolock", bus.locked, 0);

      step(1'b1, 4'd1);
      clear_stats = 1'b1;
      step(1'b1, 4'd7);
      check("clr_errcnt",  bus.err_count, 0);
      check("clr_pulse",   bus.err_pulse, 1);
      check("clr_code",    bus.err_code, 1);
      check("clr_wrapcnt", bus.wrap_count, 0);
      check("clr_sat",     bus_s.err_count, 0);

      for (int i = 0; i < 5; i++) begin
         step(1'b1, 4'd1);
         step(1'b1, 4'd9);
      end
      check("sat_wide",   bus.err_count, 5);
      check("sat_narrow", bus_s.err_count, 3);

      step(1'b1, 4'd1);
      #2;
      reset = 1'b0;
      #1;
      check("arst_locked", bus.locked, 0);
      check("arst_exp",    bus.expected, 0);
      check("arst_errcnt", bus.err_count, 0);
      check("arst_sat",    bus_s.err_count, 0);
      check("arst_code",   bus.err_code, 0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      step(1'b0, 4'd0);
      check("post_rst_locked", bus.locked, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/odd_count_checker.md
# odd_count_checker

Sequence checker that sits on the output side of the odd counter and verifies the value stream it produces. It hunts for lock on an odd value, then checks every valid sample against the expected sequence 1, 3, 5, …, 15, 1, … (4-bit wrap). It reports mismatches, even values and stalls as one-cycle error pulses with a code, and keeps saturating error and wrap statistics for the bench and for debug readout.

## Interface
Parameters:
- `GAP_MAX`, default 8: number of consecutive idle cycles (`valid_in`=0) while LOCKED that raises a timeout; legal range 1–255.
- `STAT_W`, default 8: width of the statistics counters.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low; drives all state to reset values immediately.
- `count_in`, input, 4: counter value under check.
- `valid_in`, input, 1: `count_in` is sampled this cycle.
- `restart`, input, 1: synchronous, active-high; return to HUNT because the counter was reset.
- `clear_stats`, input, 1: synchronous, active-high; zero `err_count` and `wrap_count`.
- `locked`, output, 1: FSM is in LOCKED.
- `expected`, output, 4: next value expected while LOCKED; 0 in HUNT.
- `err_pulse`, output, 1: one-cycle error strobe.
- `err_code`, output, 2: 00 none, 01 odd mismatch, 10 even value, 11 timeout; held until the next error, `restart` or reset.
- `err_count`, output, `STAT_W`: saturating error count.
- `wrap_count`, output, `STAT_W`: saturating count of correct 15→1 transitions.

## Operation
- Next value is `nxt(x) = x + 2` mod 16, so 15→1.
- The FSM has two states, HUNT and LOCKED.
- **HUNT (reset state):**
  - `valid_in`=1 with an odd `count_in`: `expected` ← `nxt(count_in)`, go to LOCKED, `gap_cnt` ← 0.
  - Even values and idle cycles are ignored; no error is raised.
- **LOCKED, `valid_in`=1:**
  - `count_in == expected`: `expected` ← `nxt(expected)`, `gap_cnt` ← 0. If `count_in` = 15, `wrap_count` increments.
  - Mismatch, odd value: `err_code`=01. Mismatch, even value: `err_code`=10. In both cases `err_pulse`=1, `err_count` increments, `expected` ← 0, go to HUNT.
- **LOCKED, `valid_in`=0:**
  - `gap_cnt` increments.
  - If `gap_cnt == GAP_MAX-1` on that edge, it is a timeout: `err_code`=11, `err_pulse`=1, `err_count` increments, go to HUNT.
- **`restart`:** go to HUNT, `expected` ← 0, `err_code` ← 00, `gap_cnt` ← 0. Statistics are kept.
- **Priority:** `restart` beats `valid_in` and timeout. A sample arriving with `restart` is discarded; no lock or error results from it.
- **`clear_stats` with a same-cycle increment:** the counter ends at 0. `clear_stats` does not affect the FSM.
- **Saturation:** `err_count` and `wrap_count` hold at 2^STAT_W − 1.
- **Reset values** (while `reset`=0): `locked`=0, `expected`=0, `err_pulse`=0, `err_code`=00, `err_count`=0, `wrap_count`=0, `gap_cnt`=0, state HUNT.

## Timing
- All outputs are registered. A sample taken at edge N is reflected at outputs right after edge N (one-cycle latency from input to status).
- `err_pulse` is high for exactly one cycle per error. It is never asserted in HUNT or on a `restart` cycle.
- Lock takes one valid odd sample. The first checked sample is the next `valid_in`.
- A timeout fires on the GAP_MAX-th consecutive idle cycle after the last valid sample in LOCKED.
- Back-to-back: a mismatch edge leaves the block in HUNT. A valid odd sample on the following cycle re-locks with no further error.
- Asserting `reset` mid-operation clears outputs asynchronously, without waiting for `clk`. Deassertion is sampled at the next edge.

## Test plan
- **Reset and lock:** hold `reset`=0 for 2 cycles → all outputs 0. Release, feed valid 1,3,5 → `locked`=1 after the first edge, `expected`=7, `err_count`=0.
- **Wrap:** feed valid 1,3,…,15,1,3 → `wrap_count`=1, no `err_pulse`, `expected`=5.
- **Mismatch and even errors:**
  - Locked at `expected`=5, feed 9 → `err_pulse` for 1 cycle, `err_code`=01, `err_count`=1, `locked`=0.
  - Re-lock on 3, then feed 6 → `err_code`=10, `err_count`=2.
- **Timeout:** `GAP_MAX`=8. Lock on 1, then 8 idle cycles → `err_code`=11 on the 8th edge, `locked`=0. With 7 idle cycles, then 3 → no error, `expected`=5.
- **Priority:**
  - `restart` together with valid 4 while LOCKED → HUNT, no error, `err_code`=00.
  - `clear_stats` on the same edge as a mismatch → `err_count`=0, `err_pulse`=1.
- **Saturation:** `STAT_W`=2, force 5 mismatches → `err_count` stays 3. Async `reset` pulse mid-sequence → all outputs 0 without a clock edge.
